// File: rtl/marker_pkg.sv
// rtl/marker_pkg.sv - shared constants and state types for the marker centroid sequencer
package marker_pkg;

    localparam int H_RES      = 320;
    localparam int V_RES      = 240;
    localparam int FRAME_PIX  = H_RES * V_RES;
    localparam int ADDR_W     = 17;
    localparam int SUM_W      = 32;
    localparam int MIN_PIXELS = 4;
    localparam logic [11:0] KEY_COLOUR = 12'h00F;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        DIV,
        RESULT
    } scan_state_t;

    // Sub-steps of DIV: X and Y quotients share one divider back to back.
    typedef enum logic [1:0] {
        DIV_X_START,
        DIV_X_RUN,
        DIV_Y_START,
        DIV_Y_RUN
    } div_phase_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring sequential divider, one quotient bit per cycle after a load cycle
module seq_divider #(
    parameter int W  = 32,
    parameter int QW = 9
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          running;

    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          take;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  quo_nxt;

    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dvs};
        take    = ~diff[W];
        rem_nxt = take ? diff[W-1:0] : shifted[W-1:0];
        quo_nxt = {quo[W-2:0], take};
    end

    // done marks the final iteration; the quotient is taken from the next-state value
    // so the caller can latch it on the same edge the divider finishes.
    assign done     = running && (cnt == CW'(1));
    assign quotient = quo_nxt[QW-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem     <= '0;
            quo     <= dividend;
            dvs     <= divisor;
            cnt     <= CW'(W);
            running <= 1'b1;
        end else if (running) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/marker_scan_ctrl.sv
// rtl/marker_scan_ctrl.sv - per-frame key-colour scan, centroid divide and valid/ready hand-off
import marker_pkg::*;

module marker_scan_ctrl #(
    parameter int H_RES  = marker_pkg::H_RES,
    parameter int V_RES  = marker_pkg::V_RES,
    parameter int ADDR_W = marker_pkg::ADDR_W,
    parameter int SUM_W  = marker_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              vsync,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [11:0]       fb_pixel,
    output logic [8:0]        cx,
    output logic [7:0]        cy,
    output logic              marker_found,
    output logic [ADDR_W-1:0] pixel_count,
    output logic              centroid_valid,
    input  logic              centroid_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int FRAME_PIX = H_RES * V_RES;

    scan_state_t state, state_nxt;
    div_phase_t  div_phase, div_phase_nxt;

    logic              vsync_q;
    logic              vsync_rise;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        x;
    logic [7:0]        y;
    logic [8:0]        x_d;
    logic [7:0]        y_d;
    logic              rd_valid;
    logic [SUM_W-1:0]  sum_x;
    logic [SUM_W-1:0]  sum_y;
    logic [ADDR_W-1:0] count;

    logic              div_start;
    logic [SUM_W-1:0]  div_dividend;
    logic              div_done;
    logic [8:0]        div_quotient;

    assign fb_addr = addr;

    always_comb begin
        state_nxt      = state;
        div_phase_nxt  = div_phase;
        div_start      = 1'b0;
        div_dividend   = sum_x;
        fb_rd_en       = 1'b0;
        centroid_valid = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (vsync_rise && enable) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                fb_rd_en = 1'b1;
                if (addr == ADDR_W'(FRAME_PIX - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt     = DIV;
                div_phase_nxt = DIV_X_START;
            end
            DIV: begin
                case (div_phase)
                    DIV_X_START: begin
                        if (count < ADDR_W'(MIN_PIXELS)) begin
                            state_nxt = RESULT;
                        end else begin
                            div_start     = 1'b1;
                            div_phase_nxt = DIV_X_RUN;
                        end
                    end
                    DIV_X_RUN: begin
                        if (div_done) begin
                            div_phase_nxt = DIV_Y_START;
                        end
                    end
                    DIV_Y_START: begin
                        div_start     = 1'b1;
                        div_dividend  = sum_y;
                        div_phase_nxt = DIV_Y_RUN;
                    end
                    default: begin
                        if (div_done) begin
                            state_nxt = RESULT;
                        end
                    end
                endcase
            end
            RESULT: begin
                centroid_valid = 1'b1;
                if (centroid_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            div_phase    <= DIV_X_START;
            vsync_q      <= 1'b0;
            vsync_rise   <= 1'b0;
            addr         <= '0;
            x            <= '0;
            y            <= '0;
            x_d          <= '0;
            y_d          <= '0;
            rd_valid     <= 1'b0;
            sum_x        <= '0;
            sum_y        <= '0;
            count        <= '0;
            cx           <= '0;
            cy           <= '0;
            marker_found <= 1'b0;
            pixel_count  <= '0;
            overrun      <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_phase  <= div_phase_nxt;
            vsync_q    <= vsync;
            vsync_rise <= vsync & ~vsync_q;
            rd_valid   <= fb_rd_en;
            x_d        <= x;
            y_d        <= y;

            if (vsync_rise && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (vsync_rise && enable) begin
                        addr  <= '0;
                        x     <= '0;
                        y     <= '0;
                        sum_x <= '0;
                        sum_y <= '0;
                        count <= '0;
                    end
                end
                SCAN: begin
                    if (addr != ADDR_W'(FRAME_PIX - 1)) begin
                        addr <= addr + ADDR_W'(1);
                    end
                    if (x == 9'(H_RES - 1)) begin
                        x <= '0;
                        y <= y + 8'd1;
                    end else begin
                        x <= x + 9'd1;
                    end
                end
                DIV: begin
                    case (div_phase)
                        DIV_X_START: begin
                            pixel_count <= count;
                            if (count < ADDR_W'(MIN_PIXELS)) begin
                                marker_found <= 1'b0;
                            end
                        end
                        DIV_X_RUN: begin
                            if (div_done) begin
                                cx <= div_quotient;
                            end
                        end
                        DIV_Y_RUN: begin
                            if (div_done) begin
                                cy           <= div_quotient[7:0];
                                marker_found <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase

            // Read data lags the strobe by one cycle; x_d/y_d carry its coordinates.
            if (rd_valid && (fb_pixel == KEY_COLOUR)) begin
                sum_x <= sum_x + SUM_W'(x_d);
                sum_y <= sum_y + SUM_W'(y_d);
                count <= count + ADDR_W'(1);
            end
        end
    end

    seq_divider #(
        .W  (SUM_W),
        .QW (9)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (SUM_W'(count)),
        .done     (div_done),
        .quotient (div_quotient)
    );

endmodule

// File: tb/tb_marker_scan_ctrl.sv
// tb/tb_marker_scan_ctrl.sv - self-checking bench for marker_scan_ctrl on a reduced 32x24 frame
module tb_marker_scan_ctrl;

    localparam int H    = 32;
    localparam int V    = 24;
    localparam int NPIX = H * V;
    localparam int AW   = 17;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          vsync;
    logic          fb_rd_en;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_pixel = 12'h000;
    logic [8:0]    cx;
    logic [7:0]    cy;
    logic          marker_found;
    logic [AW-1:0] pixel_count;
    logic          centroid_valid;
    logic          centroid_ready;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    marker_scan_ctrl #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (AW),
        .SUM_W  (32)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .vsync          (vsync),
        .fb_rd_en       (fb_rd_en),
        .fb_addr        (fb_addr),
        .fb_pixel       (fb_pixel),
        .cx             (cx),
        .cy             (cy),
        .marker_found   (marker_found),
        .pixel_count    (pixel_count),
        .centroid_valid (centroid_valid),
        .centroid_ready (centroid_ready),
        .busy           (busy),
        .overrun        (overrun)
    );

    logic [11:0] mem [NPIX];

    always @(posedge clk) begin
        if (fb_rd_en) fb_pixel <= mem[fb_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int exp_count = 0;
    int exp_cx    = 0;
    int exp_cy    = 0;
    int exp_found = 0;

    task automatic clear_frame();
        for (int i = 0; i < NPIX; i++) mem[i] = 12'h000;
    endtask

    task automatic put(input int a, input logic [11:0] c);
        mem[a] = c;
    endtask

    // Centroid by definition: average column/row of every key-colour pixel.
    task automatic model_frame();
        int n, sx, sy;
        n = 0; sx = 0; sy = 0;
        for (int a = 0; a < NPIX; a++) begin
            if (mem[a] == 12'h00F) begin
                n++;
                sx += a % H;
                sy += a / H;
            end
        end
        exp_count = n;
        if (n >= 4) begin
            exp_cx    = sx / n;
            exp_cy    = sy / n;
            exp_found = 1;
        end else begin
            exp_found = 0;
        end
    endtask

    int rd_idx = 0;

    always @(negedge clk) begin
        if (!busy) rd_idx = 0;
        if (resetn && fb_rd_en) begin
            chk("fb_addr_seq", fb_addr, rd_idx);
            rd_idx++;
        end
        if (resetn && centroid_valid) begin
            chk("cx", cx, exp_cx);
            chk("cy", cy, exp_cy);
            chk("marker_found", marker_found, exp_found);
            chk("pixel_count", pixel_count, exp_count);
        end
    end

    task automatic run_frame(input int exp_lat, input int glitch_addr, input int en_addr);
        int  n;
        bit  fin;
        n   = 0;
        fin = 0;
        vsync = 1'b1;
        while (!fin) begin
            @(negedge clk);
            n++;
            if (n == 3) vsync = 1'b0;
            if (glitch_addr >= 0 && fb_rd_en) begin
                if (fb_addr == AW'(glitch_addr)) vsync = 1'b1;
                if (fb_addr == AW'(glitch_addr + 4)) vsync = 1'b0;
            end
            if (en_addr >= 0 && fb_rd_en && fb_addr == AW'(en_addr)) enable = 1'b0;
            if (centroid_valid) fin = 1;
            else if (n >= 5000) fin = 1;
        end
        vsync = 1'b0;
        chk("latency", n, exp_lat);
    endtask

    task automatic accept();
        @(negedge clk);
        chk("valid_drop", centroid_valid, 0);
        chk("busy_after_accept", busy, 0);
    endtask

    task automatic block_frame();
        clear_frame();
        put(20 * H + 10, 12'h00F);
        put(20 * H + 11, 12'h00F);
        put(21 * H + 10, 12'h00F);
        put(21 * H + 11, 12'h00F);
        put(5, 12'h00E);
        put(100, 12'h10F);
    endtask

    task automatic corner_frame();
        clear_frame();
        put(0, 12'h00F);
        put(NPIX - 1, 12'h00F);
        put(H + 1, 12'h00F);
        put(H + 2, 12'h00F);
    endtask

    int seen;

    initial begin
        resetn = 1'b0;
        enable = 1'b1;
        vsync  = 1'b0;
        centroid_ready = 1'b1;
        clear_frame();
        repeat (3) @(negedge clk);
        chk("rst_fb_rd_en", fb_rd_en, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_found", marker_found, 0);
        chk("rst_count", pixel_count, 0);
        chk("rst_valid", centroid_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 2x2 block at columns 10..11, rows 20..21, plus two near-miss colours
        block_frame();
        model_frame();
        chk("model_block_cx", exp_cx, 10);
        chk("model_block_cy", exp_cy, 20);
        chk("model_block_n", exp_count, 4);
        run_frame(1 + NPIX + 1 + 66 + 1, -1, -1);
        chk("block_cx", cx, 10);
        chk("block_cy", cy, 20);
        chk("block_overrun", overrun, 0);
        accept();

        // empty frame: no marker, previous centroid retained
        clear_frame();
        model_frame();
        chk("model_black_found", exp_found, 0);
        run_frame(1 + NPIX + 1 + 1 + 1, -1, -1);
        chk("black_found", marker_found, 0);
        chk("black_count", pixel_count, 0);
        chk("black_cx_kept", cx, 10);
        chk("black_cy_kept", cy, 20);
        accept();

        // corners + two pixels: sum_x 0+31+1+2=34, sum_y 0+23+1+1=25
        corner_frame();
        model_frame();
        chk("model_corner_cx", exp_cx, 8);
        chk("model_corner_cy", exp_cy, 6);
        centroid_ready = 1'b0;
        run_frame(1 + NPIX + 1 + 66 + 1, -1, -1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!centroid_valid) seen++;
            if (i == 40) vsync = 1'b1;
            if (i == 44) vsync = 1'b0;
        end
        chk("hold_valid_drops", seen, 0);
        chk("hold_overrun", overrun, 1);
        centroid_ready = 1'b1;
        accept();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || fb_rd_en) seen++;
        end
        chk("no_scan_after_missed_vsync", seen, 0);

        // reset pulse while the divider is running
        block_frame();
        model_frame();
        vsync = 1'b1;
        for (int n = 1; n <= 800; n++) begin
            @(negedge clk);
            if (n == 3) vsync = 1'b0;
        end
        chk("mid_div_busy", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_cx = 0;
        exp_cy = 0;
        chk("div_rst_busy", busy, 0);
        chk("div_rst_valid", centroid_valid, 0);
        chk("div_rst_cx", cx, 0);
        chk("div_rst_cy", cy, 0);
        chk("div_rst_overrun", overrun, 0);
        repeat (2) @(negedge clk);

        // second vsync mid-scan: flagged, result of the running frame intact
        corner_frame();
        model_frame();
        run_frame(1 + NPIX + 1 + 66 + 1, 300, -1);
        chk("glitch_overrun", overrun, 1);
        chk("glitch_cx", cx, 8);
        chk("glitch_cy", cy, 6);
        chk("glitch_count", pixel_count, 4);
        accept();

        // enable drops mid-scan: frame still completes, then no further scans
        block_frame();
        model_frame();
        run_frame(1 + NPIX + 1 + 66 + 1, -1, 200);
        chk("endrop_cx", cx, 10);
        chk("endrop_found", marker_found, 1);
        accept();
        vsync = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) vsync = 1'b0;
            if (busy) seen++;
        end
        chk("disabled_no_scan", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
